// File: rtl/feature_extractor.sv
// Row-streaming shape feature extractor for the digit perceptron front end.
// Counts straight strokes (edges) and one-column outline steps (curves) over a frame.
module feature_extractor #(
    parameter int IMG_ROWS = 8,
    parameter int RUN_MIN  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] row_data,
    input  logic       row_valid,
    output logic       row_ready,
    input  logic       frame_clr,
    output logic [2:0] edges,
    output logic [3:0] curves,
    output logic       feat_valid,
    input  logic       feat_ready
);
    localparam int RW = $clog2(IMG_ROWS + 1);
    localparam int CW = $clog2(RUN_MIN + 1);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] row_cnt_q, row_cnt_d;
    logic [CW-1:0] run_q [8];
    logic [CW-1:0] run_d [8];
    logic [CW-1:0] run_next [8];
    logic [2:0]    edge_acc_q, edge_acc_d;
    logic [3:0]    curve_acc_q, curve_acc_d;
    logic          prev_nz_q, prev_nz_d;
    logic          prev_qual_q, prev_qual_d;
    logic [2:0]    lo_prev_q, lo_prev_d;
    logic [2:0]    hi_prev_q, hi_prev_d;
    logic [2:0]    edges_q, edges_d;
    logic [3:0]    curves_q, curves_d;

    logic [8-RUN_MIN:0] win_hit;
    logic [7:0]         col_hit;
    logic               qual;
    logic               h_inc;
    logic [3:0]         v_cnt;
    logic [2:0]         lo, hi;
    logic               curve_eval;
    logic               lo_step, hi_step;
    logic [4:0]         edge_sum, curve_sum;
    logic [2:0]         edge_sat;
    logic [3:0]         curve_sat;
    logic               row_accept;

    // A row qualifies as a horizontal stroke if any RUN_MIN-wide window is all ink.
    genvar gi;
    generate
        for (gi = 0; gi <= 8 - RUN_MIN; gi++) begin : g_win
            assign win_hit[gi] = &row_data[gi +: RUN_MIN];
        end
        for (gi = 0; gi < 8; gi++) begin : g_col
            assign col_hit[gi]  = row_data[gi] && (run_q[gi] == CW'(RUN_MIN - 1));
            assign run_next[gi] = !row_data[gi] ? '0 :
                                  (run_q[gi] == CW'(RUN_MIN)) ? run_q[gi] : run_q[gi] + 1'b1;
        end
    endgenerate

    assign qual  = |win_hit;
    assign h_inc = qual && !prev_qual_q;

    always_comb begin
        v_cnt = '0;
        lo    = '0;
        hi    = '0;
        for (int i = 0; i < 8; i++) begin
            v_cnt = v_cnt + {3'b000, col_hit[i]};
        end
        for (int i = 7; i >= 0; i--) begin
            if (row_data[i]) lo = 3'(i);
        end
        for (int i = 0; i < 8; i++) begin
            if (row_data[i]) hi = 3'(i);
        end
    end

    assign curve_eval = prev_nz_q && (row_data != 8'h00);
    assign lo_step    = ({1'b0, lo} == {1'b0, lo_prev_q} + 4'd1) ||
                        ({1'b0, lo_prev_q} == {1'b0, lo} + 4'd1);
    assign hi_step    = ({1'b0, hi} == {1'b0, hi_prev_q} + 4'd1) ||
                        ({1'b0, hi_prev_q} == {1'b0, hi} + 4'd1);

    // Sum every contribution of the row first, then clamp once.
    assign edge_sum  = {2'b00, edge_acc_q} + {4'b0000, h_inc} + {1'b0, v_cnt};
    assign curve_sum = {1'b0, curve_acc_q}
                     + {4'b0000, curve_eval && lo_step}
                     + {4'b0000, curve_eval && hi_step};
    assign edge_sat  = (edge_sum > 5'd7)   ? 3'd7  : edge_sum[2:0];
    assign curve_sat = (curve_sum > 5'd15) ? 4'd15 : curve_sum[3:0];

    assign row_accept = row_valid && (state_q == ACCUM);

    always_comb begin
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        edge_acc_d  = edge_acc_q;
        curve_acc_d = curve_acc_q;
        prev_nz_d   = prev_nz_q;
        prev_qual_d = prev_qual_q;
        lo_prev_d   = lo_prev_q;
        hi_prev_d   = hi_prev_q;
        edges_d     = edges_q;
        curves_d    = curves_q;
        for (int i = 0; i < 8; i++) begin
            run_d[i] = run_q[i];
        end

        case (state_q)
            ACCUM: begin
                if (frame_clr) begin
                    row_cnt_d   = '0;
                    edge_acc_d  = '0;
                    curve_acc_d = '0;
                    prev_nz_d   = 1'b0;
                    prev_qual_d = 1'b0;
                    lo_prev_d   = '0;
                    hi_prev_d   = '0;
                    for (int i = 0; i < 8; i++) begin
                        run_d[i] = '0;
                    end
                end else if (row_accept) begin
                    row_cnt_d   = row_cnt_q + 1'b1;
                    edge_acc_d  = edge_sat;
                    curve_acc_d = curve_sat;
                    prev_nz_d   = (row_data != 8'h00);
                    prev_qual_d = qual;
                    lo_prev_d   = lo;
                    hi_prev_d   = hi;
                    for (int i = 0; i < 8; i++) begin
                        run_d[i] = run_next[i];
                    end
                    if (row_cnt_q == RW'(IMG_ROWS - 1)) begin
                        edges_d  = edge_sat;
                        curves_d = curve_sat;
                        state_d  = HOLD;
                    end
                end
            end
            HOLD: begin
                // Results stay on edges/curves; only the working state is wiped.
                if (feat_ready) begin
                    state_d     = ACCUM;
                    row_cnt_d   = '0;
                    edge_acc_d  = '0;
                    curve_acc_d = '0;
                    prev_nz_d   = 1'b0;
                    prev_qual_d = 1'b0;
                    lo_prev_d   = '0;
                    hi_prev_d   = '0;
                    for (int i = 0; i < 8; i++) begin
                        run_d[i] = '0;
                    end
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACCUM;
            row_cnt_q   <= '0;
            edge_acc_q  <= '0;
            curve_acc_q <= '0;
            prev_nz_q   <= 1'b0;
            prev_qual_q <= 1'b0;
            lo_prev_q   <= '0;
            hi_prev_q   <= '0;
            edges_q     <= '0;
            curves_q    <= '0;
            for (int i = 0; i < 8; i++) begin
                run_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            edge_acc_q  <= edge_acc_d;
            curve_acc_q <= curve_acc_d;
            prev_nz_q   <= prev_nz_d;
            prev_qual_q <= prev_qual_d;
            lo_prev_q   <= lo_prev_d;
            hi_prev_q   <= hi_prev_d;
            edges_q     <= edges_d;
            curves_q    <= curves_d;
            for (int i = 0; i < 8; i++) begin
                run_q[i] <= run_d[i];
            end
        end
    end

    assign row_ready  = (state_q == ACCUM);
    assign feat_valid = (state_q == HOLD);
    assign edges      = edges_q;
    assign curves     = curves_q;
endmodule

// File: tb/tb_feature_extractor.sv
// Directed bench for feature_extractor: hand-computed frames, backpressure, abort and reset.
module tb_feature_extractor;
    logic       clk;
    logic       rst;
    logic [7:0] row_data;
    logic       row_valid;
    logic       row_ready;
    logic       frame_clr;
    logic [2:0] edges;
    logic [3:0] curves;
    logic       feat_valid;
    logic       feat_ready;

    int checks = 0;
    int errors = 0;
    logic [7:0] frm [8];

    feature_extractor #(.IMG_ROWS(8), .RUN_MIN(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .row_data  (row_data),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .frame_clr (frame_clr),
        .edges     (edges),
        .curves    (curves),
        .feat_valid(feat_valid),
        .feat_ready(feat_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_row(input logic [7:0] d);
        row_valid = 1'b1;
        row_data  = d;
        @(posedge clk);
        #1;
        row_valid = 1'b0;
    endtask

    // Sends frm[0..7]; checks the 1-cycle result latency and values; completes the handshake if feat_ready is high.
    task automatic run_frame(input string name, input logic [7:0] e_exp, input logic [7:0] c_exp);
        for (int i = 0; i < 7; i++) begin
            push_row(frm[i]);
        end
        row_valid = 1'b1;
        row_data  = frm[7];
        check({name, "_valid_before"}, {7'd0, feat_valid}, 8'd0);
        @(posedge clk);
        #1;
        row_valid = 1'b0;
        check({name, "_valid"}, {7'd0, feat_valid}, 8'd1);
        check({name, "_ready_low"}, {7'd0, row_ready}, 8'd0);
        check({name, "_edges"}, {5'd0, edges}, e_exp);
        check({name, "_curves"}, {4'd0, curves}, c_exp);
        $display("frame %s edges=%0d curves=%0d", name, edges, curves);
        if (feat_ready) begin
            @(posedge clk);
            #1;
            check({name, "_ready_back"}, {7'd0, row_ready}, 8'd1);
            check({name, "_valid_drop"}, {7'd0, feat_valid}, 8'd0);
        end
    endtask

    task automatic set_frame(input logic [7:0] a, input int n, input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            frm[i] = (i < n) ? a : b;
        end
    endtask

    task automatic set_diag();
        for (int i = 0; i < 8; i++) begin
            frm[i] = 8'h01 << i;
        end
    endtask

    initial begin
        rst        = 1'b1;
        row_data   = 8'h00;
        row_valid  = 1'b0;
        frame_clr  = 1'b0;
        feat_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_edges", {5'd0, edges}, 8'd0);
        check("rst_curves", {4'd0, curves}, 8'd0);
        check("rst_valid", {7'd0, feat_valid}, 8'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_ready", {7'd0, row_ready}, 8'd1);

        set_frame(8'h00, 8, 8'h00); run_frame("blank", 8'd0, 8'd0);
        set_frame(8'h08, 8, 8'h00); run_frame("digit1", 8'd1, 8'd0);
        set_frame(8'hFF, 1, 8'h00); run_frame("hbar1", 8'd1, 8'd0);
        set_frame(8'hFF, 2, 8'h00); run_frame("hbar2", 8'd1, 8'd0);
        set_frame(8'hFF, 4, 8'h00); run_frame("hbar4", 8'd7, 8'd0);
        set_diag();                 run_frame("diag", 8'd0, 8'd14);

        // Backpressure: rows presented in HOLD must be ignored.
        feat_ready = 1'b0;
        set_frame(8'hFF, 4, 8'h00); run_frame("bp", 8'd7, 8'd0);
        row_valid = 1'b1;
        row_data  = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", {7'd0, feat_valid}, 8'd1);
            check("bp_hold_ready", {7'd0, row_ready}, 8'd0);
            check("bp_hold_edges", {5'd0, edges}, 8'd7);
            check("bp_hold_curves", {4'd0, curves}, 8'd0);
        end
        row_valid  = 1'b0;
        feat_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_ready", {7'd0, row_ready}, 8'd1);
        set_frame(8'h08, 8, 8'h00); run_frame("bp_next", 8'd1, 8'd0);

        // Abort after 4 rows; the row accepted alongside frame_clr is dropped.
        for (int i = 0; i < 4; i++) push_row(8'hFF);
        frame_clr = 1'b1;
        row_valid = 1'b1;
        row_data  = 8'hFF;
        @(posedge clk);
        #1;
        frame_clr = 1'b0;
        row_valid = 1'b0;
        set_diag(); run_frame("clr_diag", 8'd0, 8'd14);

        // Async reset mid-frame, asserted between clock edges.
        for (int i = 0; i < 3; i++) push_row(8'hFF);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_edges", {5'd0, edges}, 8'd0);
        check("midrst_curves", {4'd0, curves}, 8'd0);
        check("midrst_valid", {7'd0, feat_valid}, 8'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_diag(); run_frame("rst_diag", 8'd0, 8'd14);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/feature_extractor.md
Name: feature_extractor

Overview:
- Streaming front end that feeds the digit-classification perceptron.
- Takes a monochrome 8-column digit bitmap, one row per handshake.
- Accumulates two shape features over the frame: edges (straight horizontal or vertical strokes) and curves (single-column diagonal steps of the stroke outline).
- Presents the pair `{edges[2:0], curves[3:0]}` on a valid/ready output, sized to match the perceptron's feature inputs.

Parameters:
- IMG_ROWS, 8: rows per frame; legal range 2..16.
- RUN_MIN, 4: minimum run length, in pixels, that counts as a straight stroke; legal range 2..8.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- row_data  input  8  one bitmap row; bit i = column i; 1 = ink.
- row_valid  input  1  row_data valid.
- row_ready  output  1  block accepts a row this cycle.
- frame_clr  input  1  synchronous abort; discards any partial frame.
- edges  output  3  edge count, saturating at 7.
- curves  output  4  curve count, saturating at 15.
- feat_valid  output  1  edges/curves valid.
- feat_ready  input  1  downstream accepts the features.

Behaviour:
- Reset (async, active-high) clears all state and outputs:
  - edges=0, curves=0, feat_valid=0.
  - row counter=0, all column run counters=0.
  - prev-row flags cleared.
  - State = ACCUM. row_ready=1 once reset is released.
- State machine has two states:
  - ACCUM: row_ready=1, feat_valid=0.
  - HOLD: row_ready=0, feat_valid=1.
- Row accepted = row_valid & row_ready.
- ACCUM, on each accepted row, the block updates:
  - Horizontal edge (H):
    - The row "qualifies" if it contains ≥RUN_MIN contiguous ones.
    - edge_acc += 1 when the row qualifies and the previous row did not.
    - Consecutive qualifying rows therefore count once. For row 0, the previous row is treated as non-qualifying.
  - Vertical edge (V):
    - Per-column run counter increments when the bit is 1, clears when it is 0, and saturates at RUN_MIN.
    - edge_acc += 1 for every column whose counter transitions from RUN_MIN-1 to RUN_MIN this row.
    - Multiple columns may add in the same row.
  - Curves:
    - lo = lowest set bit index, hi = highest set bit index.
    - Evaluated only when both the current and previous rows are nonzero.
    - curve_acc += 1 if |lo - lo_prev| == 1.
    - curve_acc += 1 if |hi - hi_prev| == 1.
    - Up to +2 per row.
  - Saturation: edge_acc saturates at 7 and curve_acc at 15. Saturation is applied after summing all of a row's contributions.
  - Row counter increments. On the IMG_ROWS-th accepted row:
    - edges and curves are registered from the final accumulators (including that row's contribution).
    - Transition to HOLD. feat_valid rises the next cycle (1-cycle latency after the last row).
- HOLD:
  - edges and curves stay stable. Rows presented are ignored (row_ready=0).
  - On feat_valid & feat_ready:
    - Accumulators, run counters, row counter and prev flags clear.
    - Return to ACCUM. row_ready=1 the next cycle.
  - edges and curves keep their last values until the next frame completes.
- frame_clr:
  - In ACCUM: clears accumulators, counters and prev flags. A row accepted in the same cycle is dropped; clear wins.
  - In HOLD: ignored; output is never retracted.
- Back-to-back frames: maximum throughput is one frame per IMG_ROWS+1 cycles, because of the HOLD handshake cycle.
- Reset asserted mid-frame or during HOLD: immediate return to the reset state; the partial frame is lost.

Test Plan:
- Blank frame: 8 rows of 8'h00, feat_ready=1 → feat_valid=1 exactly 1 cycle after the 8th acceptance, edges=0, curves=0; row_ready=1 the following cycle.
- Digit "1": 8 rows of 8'h08 → edges=1 (column 3 vertical), curves=0.
- Horizontal bars:
  - row0=8'hFF, rest 0 → edges=1.
  - rows0-1=8'hFF → edges=1.
  - rows0-3=8'hFF → 1 horizontal + 8 vertical = 9 → edges=7 (saturated), curves=0.
- Diagonal: row r = 8'h01<<r → edges=0, curves=14.
- Backpressure:
  - Hold feat_ready=0 for 5 cycles after completion while driving row_valid=1 → feat_valid, edges and curves stable; row_ready=0; no rows consumed.
  - After the handshake, the next frame (digit "1") yields edges=1.
- Abort/reset:
  - After 4 rows, pulse frame_clr then send a full diagonal frame → curves=14.
  - Repeat with async rst mid-frame → all outputs 0 during reset, then the same correct result.
